// File: rtl/pll_spi_pkg.sv
// rtl/pll_spi_pkg.sv - shared widths, field positions and FSM states for the PLL serial link
package pll_spi_pkg;

    localparam int WORD_W      = 32;
    localparam int NUM_REGS    = 6;
    localparam int ADDR_W      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 6;

    localparam int CTRL_LSB = 0;
    localparam int CTRL_MSB = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/pll_spi_receiver_sync_edge_det.sv
// rtl/pll_spi_receiver_sync_edge_det.sv - async input synchroniser with rise/fall pulses
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pll_spi_receiver.sv
// rtl/pll_spi_receiver.sv - serial PLL register slave: shifts 32-bit words, commits on LE into a bank
module pll_spi_receiver
    import pll_spi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk_in,
    input  logic                sdata_in,
    input  logic                ss_in,
    input  logic                le_in,
    input  logic                clr_mask,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [WORD_W-1:0]   rd_data,
    output logic                word_valid,
    output logic [WORD_W-1:0]   word_data,
    output logic [ADDR_W-1:0]   word_addr,
    output logic                frame_err,
    output logic                addr_err,
    output logic [NUM_REGS-1:0] written_mask,
    output logic                all_loaded
);

    localparam logic [ADDR_W-1:0] NREGS_A  = ADDR_W'(NUM_REGS);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WORD_W + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sdata_lvl, sdata_rise, sdata_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic le_lvl, le_rise, le_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst(rst), .din(sclk_in),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sdata (.clk(clk), .rst(rst), .din(sdata_in),
        .level(sdata_lvl), .rise(sdata_rise), .fall(sdata_fall));
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ss (.clk(clk), .rst(rst), .din(ss_in),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_le (.clk(clk), .rst(rst), .din(le_in),
        .level(le_lvl), .rise(le_rise), .fall(le_fall));

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, sclk_fall, sdata_rise, sdata_fall, le_lvl, le_fall};

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ss_pend_q, ss_pend_d;
    logic [WORD_W-1:0]   bank_q [NUM_REGS];
    logic [WORD_W-1:0]   bank_d [NUM_REGS];
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
    logic                valid_q, valid_d, ferr_q, ferr_d, aerr_q, aerr_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]   addr;

    assign addr = shift_q[CTRL_MSB:CTRL_LSB];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        ss_pend_d   = ss_pend_q;
        bank_d      = bank_q;
        mask_d      = clr_mask ? '0 : mask_q;
        word_data_d = word_data_q;
        word_addr_d = word_addr_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        aerr_d      = 1'b0;
        rd_data_d   = (rd_addr < NREGS_A) ? bank_q[rd_addr] : '0;

        // A final sclk edge landing with LE is shifted before the count is judged in COMMIT
        if (state_q == SHIFT && sclk_rise && !ss_lvl) begin
            shift_d = {shift_q[WORD_W-2:0], sdata_lvl};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (le_rise) begin
                    state_d   = COMMIT;
                    ss_pend_d = ss_fall;
                end else if (ss_fall) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (le_rise) begin
                    state_d   = COMMIT;
                    ss_pend_d = ss_fall;
                end else if (ss_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                end else if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                if (cnt_q != CNT_FULL) begin
                    ferr_d = 1'b1;
                end else if (addr >= NREGS_A) begin
                    aerr_d = 1'b1;
                end else begin
                    bank_d[addr] = shift_q;
                    mask_d[addr] = 1'b1;
                    word_data_d  = shift_q;
                    word_addr_d  = addr;
                    valid_d      = 1'b1;
                end
                shift_d   = '0;
                cnt_d     = '0;
                ss_pend_d = 1'b0;
                state_d   = (!ss_lvl && (ss_pend_q || ss_fall)) ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            ss_pend_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
            mask_q      <= '0;
            word_data_q <= '0;
            word_addr_q <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            aerr_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            ss_pend_q   <= ss_pend_d;
            bank_q      <= bank_d;
            mask_q      <= mask_d;
            word_data_q <= word_data_d;
            word_addr_q <= word_addr_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            aerr_q      <= aerr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign word_valid   = valid_q;
    assign word_data    = word_data_q;
    assign word_addr    = word_addr_q;
    assign frame_err    = ferr_q;
    assign addr_err     = aerr_q;
    assign written_mask = mask_q;
    assign all_loaded   = &mask_q;

endmodule

// File: tb/tb_pll_spi_receiver.sv
// tb/tb_pll_spi_receiver.sv - directed bench for pll_spi_receiver
module tb_pll_spi_receiver;
    import pll_spi_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sclk_in = 1'b0, sdata_in = 1'b0, ss_in = 1'b1, le_in = 1'b0, clr_mask = 1'b0;
    logic [ADDR_W-1:0]   rd_addr = '0;
    logic [WORD_W-1:0]   rd_data, word_data;
    logic [ADDR_W-1:0]   word_addr;
    logic                word_valid, frame_err, addr_err, all_loaded;
    logic [NUM_REGS-1:0] written_mask;

    int total = 0, bad = 0;
    int n_valid = 0, n_ferr = 0, n_aerr = 0;
    int v0, f0, a0;

    pll_spi_receiver dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .sdata_in(sdata_in), .ss_in(ss_in),
        .le_in(le_in), .clr_mask(clr_mask), .rd_addr(rd_addr), .rd_data(rd_data),
        .word_valid(word_valid), .word_data(word_data), .word_addr(word_addr),
        .frame_err(frame_err), .addr_err(addr_err), .written_mask(written_mask),
        .all_loaded(all_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_valid += int'(word_valid);
            n_ferr  += int'(frame_err);
            n_aerr  += int'(addr_err);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic half_bit();
        repeat (5) @(negedge clk);
    endtask

    task automatic snap();
        v0 = n_valid; f0 = n_ferr; a0 = n_aerr;
    endtask

    task automatic send_frame(input logic [63:0] w, input int n, input bit aligned, input bit clr_with);
        @(negedge clk);
        ss_in = 1'b1;
        repeat (4) @(negedge clk);
        ss_in = 1'b0;
        half_bit();
        for (int i = n - 1; i >= 1; i--) begin
            sdata_in = w[i];
            half_bit();
            sclk_in = 1'b1;
            half_bit();
            sclk_in = 1'b0;
        end
        sdata_in = w[0];
        half_bit();
        sclk_in = 1'b1;
        if (aligned) begin
            le_in = 1'b1;
        end else begin
            half_bit();
            sclk_in = 1'b0;
            half_bit();
            le_in = 1'b1;
        end
        if (clr_with) begin
            repeat (3) @(posedge clk);
            #1 clr_mask = 1'b1;
            @(posedge clk);
            #1 clr_mask = 1'b0;
        end
        repeat (10) @(negedge clk);
        sclk_in = 1'b0;
        le_in   = 1'b0;
        ss_in   = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_mask", {26'd0, written_mask}, 32'd0);
        check("rst_wdata", word_data, 32'd0);
        check("rst_errs", {30'd0, frame_err, addr_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        read_chk("rst_bank5", 3'd5, 32'd0);

        // single word to address 5
        snap();
        send_frame({32'd0, 32'h0058_0005}, 32, 1'b0, 1'b0);
        check("t1_valid_cnt", n_valid - v0, 1);
        check("t1_waddr", {29'd0, word_addr}, 32'd5);
        check("t1_wdata", word_data, 32'h0058_0005);
        check("t1_mask", {26'd0, written_mask}, 32'h20);
        read_chk("t1_bank5", 3'd5, 32'h0058_0005);

        // fill the remaining addresses
        send_frame({32'd0, 32'h00AB_CD04}, 32, 1'b0, 1'b0);
        send_frame({32'd0, 32'h0000_04B3}, 32, 1'b0, 1'b0);
        send_frame({32'd0, 32'h1234_5672}, 32, 1'b0, 1'b0);
        send_frame({32'd0, 32'hDEAD_BEE9}, 32, 1'b0, 1'b0);
        send_frame({32'd0, 32'h0000_0000}, 32, 1'b0, 1'b0);
        check("t2_all_loaded", {31'd0, all_loaded}, 32'd1);
        check("t2_waddr", {29'd0, word_addr}, 32'd0);
        read_chk("t2_bank0", 3'd0, 32'h0000_0000);
        read_chk("t2_bank1", 3'd1, 32'hDEAD_BEE9);
        read_chk("t2_bank2", 3'd2, 32'h1234_5672);
        read_chk("t2_bank3", 3'd3, 32'h0000_04B3);
        read_chk("t2_bank4", 3'd4, 32'h00AB_CD04);
        read_chk("t2_bank5", 3'd5, 32'h0058_0005);
        read_chk("t2_bank6", 3'd6, 32'd0);
        read_chk("t2_bank7", 3'd7, 32'd0);

        // short and long frames
        snap();
        send_frame({32'd0, 32'h7777_7771}, 31, 1'b0, 1'b0);
        check("t3_short_ferr", n_ferr - f0, 1);
        check("t3_short_valid", n_valid - v0, 0);
        read_chk("t3_bank1", 3'd1, 32'hDEAD_BEE9);
        snap();
        send_frame({31'd0, 1'b1, 32'h5555_5551}, 33, 1'b0, 1'b0);
        check("t3_long_ferr", n_ferr - f0, 1);
        check("t3_long_valid", n_valid - v0, 0);
        check("t3_mask", {26'd0, written_mask}, 32'h3F);

        // address beyond the bank
        snap();
        send_frame({32'd0, 32'h1234_5677}, 32, 1'b0, 1'b0);
        check("t4_aerr", n_aerr - a0, 1);
        check("t4_valid", n_valid - v0, 0);
        check("t4_ferr", n_ferr - f0, 0);
        check("t4_waddr", {29'd0, word_addr}, 32'd0);
        read_chk("t4_bank7", 3'd7, 32'd0);

        // reset in the middle of a frame
        @(negedge clk);
        ss_in = 1'b0;
        half_bit();
        for (int i = 0; i < 16; i++) begin
            sdata_in = 1'b1;
            half_bit();
            sclk_in = 1'b1;
            half_bit();
            sclk_in = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ss_in = 1'b1;
        check("t5_mask_rst", {26'd0, written_mask}, 32'd0);
        read_chk("t5_bank5_rst", 3'd5, 32'd0);
        snap();
        send_frame({32'd0, 32'h0000_04B3}, 32, 1'b0, 1'b0);
        check("t5_valid", n_valid - v0, 1);
        check("t5_mask", {26'd0, written_mask}, 32'h08);
        read_chk("t5_bank3", 3'd3, 32'h0000_04B3);
        read_chk("t5_bank1", 3'd1, 32'd0);

        // LE coincident with last sclk, clr_mask coincident with commit
        snap();
        send_frame({32'd0, 32'hCAFE_0002}, 32, 1'b1, 1'b1);
        check("t6_valid", n_valid - v0, 1);
        check("t6_mask", {26'd0, written_mask}, 32'h04);
        read_chk("t6_bank2", 3'd2, 32'hCAFE_0002);

        // LE with no bits at all
        snap();
        @(negedge clk);
        le_in = 1'b1;
        repeat (10) @(negedge clk);
        le_in = 1'b0;
        repeat (4) @(negedge clk);
        check("t7_empty_ferr", n_ferr - f0, 1);
        check("t7_empty_valid", n_valid - v0, 0);

        // standalone clr_mask
        @(negedge clk);
        clr_mask = 1'b1;
        @(negedge clk);
        clr_mask = 1'b0;
        @(negedge clk);
        check("t8_clr", {26'd0, written_mask}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
